decode_sequencer: RTL

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

---
 rtl/decode_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/decode_sequencer.sv
// Decode-stage sequencer: detects load-use hazards and drives the multi-beat
// stack push/pop sequences for call, return, return-from-interrupt and
// interrupt entry, followed by a single-cycle pipeline flush.
module decode_sequencer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       IntReq,
    input  logic       CallDec,
    input  logic       RetDec,
    input  logic       RtiDec,
    input  logic       ExMemRead,
    input  logic [2:0] ExRdst,
    input  logic [2:0] DecRsrc,
    input  logic [2:0] DecRdst,
    input  logic       DecUsesRsrc,
    input  logic       DecUsesRdst,
    output logic       Stall,
    output logic       ForcePush,
    output logic       ForcePop,
    output logic [1:0] PushSel,
    output logic       SecondIter,
    output logic       Flush,
    output logic       IntAck,
    output logic       Busy
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INT0  = 4'd1,
        S_INT1  = 4'd2,
        S_INT2  = 4'd3,
        S_CALL0 = 4'd4,
        S_CALL1 = 4'd5,
        S_RET0  = 4'd6,
        S_RET1  = 4'd7,
        S_RTI0  = 4'd8,
        S_RTI1  = 4'd9,
        S_RTI2  = 4'd10,
        S_FLUSH = 4'd11
    } state_t;

    // Stack word selectors carried on PushSel.
    localparam logic [1:0] SEL_PC_LO = 2'd0;
    localparam logic [1:0] SEL_PC_HI = 2'd1;
    localparam logic [1:0] SEL_FLAGS = 2'd2;

    state_t state;
    state_t state_nxt;
    logic   int_pending;
    logic   int_pending_nxt;
    logic   load_use;
    logic   rsrc_hit;
    logic   rdst_hit;
    logic   take_int;

    // Load-use hazard: a load in execute writes a register that decode reads.
    always_comb begin
        rsrc_hit = DecUsesRsrc && (ExRdst == DecRsrc);
        rdst_hit = DecUsesRdst && (ExRdst == DecRdst);
        load_use = (state == S_IDLE) && ExMemRead && (rsrc_hit || rdst_hit);
    end

    // Next-state selection; decoded flags and interrupts only act from IDLE.
    always_comb begin
        state_nxt = state;
        take_int  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!load_use) begin
                    if (CallDec) begin
                        state_nxt = S_CALL0;
                    end else if (RetDec) begin
                        state_nxt = S_RET0;
                    end else if (RtiDec) begin
                        state_nxt = S_RTI0;
                    end else if (int_pending || IntReq) begin
                        state_nxt = S_INT0;
                        take_int  = 1'b1;
                    end
                end
            end
            S_INT0:  state_nxt = S_INT1;
            S_INT1:  state_nxt = S_INT2;
            S_INT2:  state_nxt = S_FLUSH;
            S_CALL0: state_nxt = S_CALL1;
            S_CALL1: state_nxt = S_FLUSH;
            S_RET0:  state_nxt = S_RET1;
            S_RET1:  state_nxt = S_FLUSH;
            S_RTI0:  state_nxt = S_RTI1;
            S_RTI1:  state_nxt = S_RTI2;
            S_RTI2:  state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Interrupt pending flag: requests merge, cleared only when the interrupt is taken.
    always_comb begin
        int_pending_nxt = int_pending || IntReq;
        if (take_int) begin
            int_pending_nxt = 1'b0;
        end
    end

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pending-interrupt register; reset keeps requests during reset from latching.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            int_pending <= 1'b0;
        end else begin
            int_pending <= int_pending_nxt;
        end
    end

    // Moore outputs decoded from the registered state; Stall also sees the hazard.
    always_comb begin
        ForcePush  = 1'b0;
        ForcePop   = 1'b0;
        PushSel    = SEL_PC_LO;
        SecondIter = 1'b0;
        Flush      = 1'b0;
        IntAck     = 1'b0;
        Busy       = (state != S_IDLE);
        Stall      = load_use || (state != S_IDLE);
        unique case (state)
            S_INT0: begin
                ForcePush = 1'b1;
                PushSel   = SEL_PC_LO;
                IntAck    = 1'b1;
            end
            S_INT1: begin
                ForcePush = 1'b1;
                PushSel   = SEL_PC_HI;
            end
            S_INT2: begin
                ForcePush  = 1'b1;
                PushSel    = SEL_FLAGS;
                SecondIter = 1'b1;
            end
            S_CALL0: begin
                ForcePush = 1'b1;
                PushSel   = SEL_PC_LO;
            end
            S_CALL1: begin
                ForcePush  = 1'b1;
                PushSel    = SEL_PC_HI;
                SecondIter = 1'b1;
            end
            S_RET0: begin
                ForcePop = 1'b1;
                PushSel  = SEL_PC_HI;
            end
            S_RET1: begin
                ForcePop   = 1'b1;
                PushSel    = SEL_PC_LO;
                SecondIter = 1'b1;
            end
            S_RTI0: begin
                ForcePop = 1'b1;
                PushSel  = SEL_FLAGS;
            end
            S_RTI1: begin
                ForcePop = 1'b1;
                PushSel  = SEL_PC_HI;
            end
            S_RTI2: begin
                ForcePop   = 1'b1;
                PushSel    = SEL_PC_LO;
                SecondIter = 1'b1;
            end
            S_FLUSH: begin
                Flush = 1'b1;
            end
            default: begin
                Busy = (state != S_IDLE);
            end
        endcase
    end

endmodule
